// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART command sequencer.
//  - state_e     : command FSM state encoding
//  - *_BYTE_DEF  : default frame marker and response byte values
//  - cyc_per_us  : clock cycles per microsecond for a given clock in MHz
//  - to_cyc      : inter-byte timeout expressed in clock cycles
package uart_pkg;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_CMD  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_EXEC = 3'd4,
    S_WAIT = 3'd5,
    S_RESP = 3'd6
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] ACK_BYTE_DEF  = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF  = 8'h15;

  function automatic int cyc_per_us(input int clk_fre_mhz);
    return clk_fre_mhz;
  endfunction

  function automatic int to_cyc(input int clk_fre_mhz, input int timeout_us);
    return cyc_per_us(clk_fre_mhz) * timeout_us;
  endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// uart_byte_timeout: inter-byte gap counter for the command sequencer.
//  clk    in  1  system clock
//  rst    in  1  asynchronous reset, active-high
//  clr    in  1  restart the gap count (a byte was accepted)
//  en     in  1  count only while a frame is in progress; held at zero otherwise
//  expire out 1  one-cycle pulse on the last cycle of an allowed gap
module uart_byte_timeout #(
  parameter int TO_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int            CW   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    // A clear in the same cycle suppresses expiry so a late byte still counts.
    expire = en && !clr && (cnt_q == LAST);
    cnt_d  = cnt_q + 1'b1;
    if (clr || !en || expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: command sequencer between the UART and a register bank.
// Parses 4-byte frames SYNC, CMD, DATA, CSUM (CSUM = CMD ^ DATA). A good frame
// issues one register write (CMD[7]=1) or read (CMD[7]=0) at CMD[6:0] and
// returns ACK or the read byte; a bad checksum returns NAK. Bad checksums and
// inter-byte timeouts are counted in a saturating error counter.
//  clk, rst                         clock, asynchronous active-high reset
//  rx_data/rx_data_valid/rx_data_ready  byte stream from the receiver
//  tx_data/tx_data_valid/tx_data_ready  response byte to the transmitter
//  reg_addr/reg_wdata/reg_wr/reg_rd/reg_rdata  register bank access
//  err_cnt                          saturating checksum-error + timeout count
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int         CLK_FRE    = 50,
  parameter int         TIMEOUT_US = 2000,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter logic [7:0] ACK_BYTE   = ACK_BYTE_DEF,
  parameter logic [7:0] NAK_BYTE   = NAK_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       rx_data_ready,
  output logic [7:0] tx_data,
  output logic       tx_data_valid,
  input  logic       tx_data_ready,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic [7:0] err_cnt
);

  localparam int TO_CYC = to_cyc(CLK_FRE, TIMEOUT_US);

  state_e     state_q,     state_d;
  logic       rdy_q,       rdy_d;
  logic       acc_q,       acc_d;
  logic [7:0] cmd_q,       cmd_d;
  logic [7:0] data_q,      data_d;
  logic [7:0] tx_data_q,   tx_data_d;
  logic       tx_vld_q,    tx_vld_d;
  logic [6:0] reg_addr_q,  reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_wr_q,    reg_wr_d;
  logic       reg_rd_q,    reg_rd_d;
  logic       rd_cap_q,    rd_cap_d;
  logic [7:0] err_q,       err_d;

  logic accept;
  logic rx_state;
  logic to_en;
  logic to_expire;
  logic err_inc;

  uart_byte_timeout #(
    .TO_CYC (TO_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (to_en),
    .expire (to_expire)
  );

  always_comb begin
    accept   = rx_data_valid && rdy_q;
    rx_state = (state_q == S_SYNC) || (state_q == S_CMD) ||
               (state_q == S_DATA) || (state_q == S_CSUM);
    to_en    = (state_q == S_CMD) || (state_q == S_DATA) || (state_q == S_CSUM);

    state_d     = state_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    tx_data_d   = tx_data_q;
    tx_vld_d    = tx_vld_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    rd_cap_d    = rd_cap_q;
    err_d       = err_q;
    err_inc     = 1'b0;

    // Ready is a single-cycle pulse. The receiver drops valid one cycle after
    // the accept, so ready also stays low the cycle after an accept to avoid
    // taking the same held byte twice.
    acc_d = accept;
    rdy_d = rx_state && rx_data_valid && !rdy_q && !acc_q;

    case (state_q)
      S_SYNC: begin
        if (accept && (rx_data == SYNC_BYTE)) begin
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (accept) begin
          cmd_d   = rx_data;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          data_d  = rx_data;
          state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (rx_data == (cmd_q ^ data_q)) begin
            state_d = S_EXEC;
          end else begin
            tx_data_d = NAK_BYTE;
            err_inc   = 1'b1;
            state_d   = S_RESP;
          end
        end
      end
      S_EXEC: begin
        reg_addr_d = cmd_q[6:0];
        if (cmd_q[7]) begin
          reg_wr_d    = 1'b1;
          reg_wdata_d = data_q;
          tx_data_d   = ACK_BYTE;
          state_d     = S_RESP;
        end else begin
          reg_rd_d = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // Read data arrives the cycle after the strobe; capture it on the
        // first response cycle.
        rd_cap_d = 1'b1;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rd_cap_q) begin
          tx_data_d = reg_rdata;
          rd_cap_d  = 1'b0;
        end
        if (!tx_vld_q) begin
          tx_vld_d = 1'b1;
        end else if (tx_data_ready) begin
          tx_vld_d = 1'b0;
          state_d  = S_SYNC;
        end
      end
      default: begin
        state_d = S_SYNC;
      end
    endcase

    // Expiry is already masked by an accept in the same cycle.
    if (to_expire) begin
      state_d = S_SYNC;
      err_inc = 1'b1;
    end

    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_SYNC;
      rdy_q       <= 1'b0;
      acc_q       <= 1'b0;
      cmd_q       <= '0;
      data_q      <= '0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      rd_cap_q    <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      acc_q       <= acc_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      rd_cap_q    <= rd_cap_d;
      err_q       <= err_d;
    end
  end

  assign rx_data_ready = rdy_q;
  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_vld_q;
  assign reg_addr      = reg_addr_q;
  assign reg_wdata     = reg_wdata_q;
  assign reg_wr        = reg_wr_q;
  assign reg_rd        = reg_rd_q;
  assign err_cnt       = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: scoreboard queues for register writes, reads and
// response bytes are filled as frames are driven and drained by monitors.
module tb_uart_cmd_ctrl;

  localparam int CLK_FRE    = 1;
  localparam int TIMEOUT_US = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata = 8'h00;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .CLK_FRE    (CLK_FRE),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_wr        (reg_wr),
    .reg_rd        (reg_rd),
    .reg_rdata     (reg_rdata),
    .err_cnt       (err_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_tx[$];
  logic [14:0] exp_wr[$];
  logic [6:0]  exp_rd[$];
  logic        tx_hold = 1'b0;
  logic [7:0]  mem [128];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Register bank: read data is registered, valid the cycle after reg_rd.
  always @(posedge clk) begin
    if (reg_rd) reg_rdata <= mem[reg_addr];
  end

  // Register strobe monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (reg_wr) begin
          if (exp_wr.size() == 0) chk("wr_unexpected", 32'(reg_wr), 32'd0);
          else chk("wr_addr_data", 32'({reg_addr, reg_wdata}), 32'(exp_wr.pop_front()));
        end
        if (reg_rd) begin
          if (exp_rd.size() == 0) chk("rd_unexpected", 32'(reg_rd), 32'd0);
          else chk("rd_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
        end
      end
    end
  end

  // Response sink: accepts a response unless held off.
  initial begin
    tx_data_ready = 1'b0;
    forever begin
      @(negedge clk);
      tx_data_ready = 1'b0;
      if (!rst && tx_data_valid && !tx_hold) begin
        if (exp_tx.size() == 0) chk("tx_unexpected", 32'(tx_data_valid), 32'd0);
        else chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
        tx_data_ready = 1'b1;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Returns on the falling edge just after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b);
    logic got;
    got           = 1'b0;
    rx_data       = b;
    rx_data_valid = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (rx_data_ready) got = 1'b1;
    end
    if (got) @(negedge clk);
    rx_data_valid = 1'b0;
    chk("rx_accept", 32'(got), 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_tx.size() + exp_wr.size() + exp_rd.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk(tag, 32'(exp_tx.size() + exp_wr.size() + exp_rd.size()), 32'd0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_rx_ready", 32'(rx_data_ready), 32'd0);
    chk("rst_tx_valid", 32'(tx_data_valid), 32'd0);
    chk("rst_tx_data",  32'(tx_data),       32'd0);
    chk("rst_reg_addr", 32'(reg_addr),      32'd0);
    chk("rst_wdata",    32'(reg_wdata),     32'd0);
    chk("rst_strobes",  32'({reg_wr, reg_rd}), 32'd0);
    chk("rst_err_cnt",  32'(err_cnt),       32'd0);
  endtask

  initial begin
    logic saw_rdy;
    logic lost_vld;

    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[5] = 8'h5A;
    mem[9] = 8'hC3;

    rst           = 1'b1;
    rx_data       = 8'h00;
    rx_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1) good write, response held until the transmitter accepts it
    exp_wr.push_back({7'h01, 8'h3C});
    exp_tx.push_back(8'h06);
    tx_hold = 1'b1;
    send_frame(8'hA5, 8'h81, 8'h3C, 8'hBD);
    @(negedge clk);
    chk("wr_lat_c1", 32'(tx_data_valid), 32'd0);
    @(negedge clk);
    chk("wr_lat_c2", 32'(tx_data_valid), 32'd1);
    chk("ack_byte", 32'(tx_data), 32'h06);
    repeat (5) @(negedge clk);
    chk("ack_held", 32'(tx_data_valid), 32'd1);
    tx_hold = 1'b0;
    drain("t1_drain");
    chk("t1_err", 32'(err_cnt), 32'd0);

    // 2) good read
    exp_rd.push_back(7'h05);
    exp_tx.push_back(8'h5A);
    tx_hold = 1'b1;
    send_frame(8'hA5, 8'h05, 8'h00, 8'h05);
    @(negedge clk);
    chk("rd_lat_c1", 32'(tx_data_valid), 32'd0);
    @(negedge clk);
    chk("rd_lat_c2", 32'(tx_data_valid), 32'd0);
    @(negedge clk);
    chk("rd_lat_c3", 32'(tx_data_valid), 32'd1);
    tx_hold = 1'b0;
    drain("t2_drain");

    // 3) bad checksum
    exp_tx.push_back(8'h15);
    send_frame(8'hA5, 8'h81, 8'h3C, 8'h00);
    drain("t3_drain");
    chk("t3_err", 32'(err_cnt), 32'd1);

    // 4) junk before SYNC is dropped silently
    exp_wr.push_back({7'h02, 8'h11});
    exp_tx.push_back(8'h06);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'hA5, 8'h82, 8'h11, 8'h93);
    drain("t4_drain");
    chk("t4_err", 32'(err_cnt), 32'd1);

    // 5) inter-byte timeout, then a good frame
    send_byte(8'hA5);
    send_byte(8'h81);
    repeat (100) @(negedge clk);
    chk("t5_err", 32'(err_cnt), 32'd2);
    chk("t5_no_tx", 32'(tx_data_valid), 32'd0);
    exp_wr.push_back({7'h03, 8'h44});
    exp_tx.push_back(8'h06);
    send_frame(8'hA5, 8'h83, 8'h44, 8'hC7);
    drain("t5_drain");

    // 6) long transmitter back-pressure with the next byte pending
    exp_wr.push_back({7'h04, 8'h55});
    exp_tx.push_back(8'h06);
    tx_hold = 1'b1;
    send_frame(8'hA5, 8'h84, 8'h55, 8'hD1);
    repeat (2) @(negedge clk);
    rx_data       = 8'hA5;
    rx_data_valid = 1'b1;
    saw_rdy  = 1'b0;
    lost_vld = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rx_data_ready) saw_rdy = 1'b1;
      if (!tx_data_valid) lost_vld = 1'b1;
    end
    chk("bp_rx_ready", 32'(saw_rdy), 32'd0);
    chk("bp_tx_valid_lost", 32'(lost_vld), 32'd0);
    exp_wr.push_back({7'h06, 8'h77});
    exp_tx.push_back(8'h06);
    tx_hold = 1'b0;
    send_frame(8'hA5, 8'h86, 8'h77, 8'hF1);
    drain("t6_drain");

    // 7) reset in the middle of a frame
    send_byte(8'hA5);
    send_byte(8'h81);
    rst = 1'b1;
    #1;
    chk_reset_outs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_rd.push_back(7'h09);
    exp_tx.push_back(8'hC3);
    send_frame(8'hA5, 8'h09, 8'h00, 8'h09);
    drain("t7_drain");
    chk("t7_err", 32'(err_cnt), 32'd0);

    // 8) error counter saturation
    for (int k = 1; k <= 256; k++) begin
      exp_tx.push_back(8'h15);
      send_frame(8'hA5, 8'h81, 8'h3C, 8'h00);
      drain("t8_drain");
      if (k == 254) chk("err_fe", 32'(err_cnt), 32'hFE);
      if (k == 255) chk("err_ff", 32'(err_cnt), 32'hFF);
      if (k == 256) chk("err_sat", 32'(err_cnt), 32'hFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
